mips32_prog_loader: RTL

MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

---
 rtl/mips32_prog_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mips32_prog_loader.sv
// Byte-stream program loader: parses SYNC/ADDR/CNT framed words into memory writes
// and holds the CPU until a frame completes. Optional checksum byte: PROG_LOADER_CHKSUM_EN.
module mips32_prog_loader #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 10
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 load_done,
  output logic                 load_err,
  output logic                 cpu_hold
);

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [16:0] MEM_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    CNT_HI,
    CNT_LO,
    DATA,
`ifdef PROG_LOADER_CHKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t            state_r;
  logic [7:0]        addr_hi_r;
  logic [ADDR_W-1:0] start_r;
  logic [7:0]        cnt_hi_r;
  logic [15:0]       words_left_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       word_sh_r;

  logic [15:0]       n_s;
  logic [16:0]       end_s;
  logic [31:0]       word_s;
  logic              is_sync_s;

`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0]        chk_r;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // Frame length and bounds are judged on the CNT_LO byte itself, before it is registered.
  assign n_s       = {cnt_hi_r, in_data};
  assign end_s     = 17'(start_r) + 17'(n_s);
  assign word_s    = {word_sh_r, in_data};
  assign is_sync_s = (in_data == SYNC_BYTE);
  assign in_ready  = 1'b1;

  // Frame parser FSM with registered memory-write and status outputs.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      addr_hi_r    <= 8'h00;
      start_r      <= '0;
      cnt_hi_r     <= 8'h00;
      words_left_r <= 16'h0000;
      wr_addr_r    <= '0;
      byte_cnt_r   <= 2'd0;
      word_sh_r    <= 24'h000000;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      cpu_hold     <= 1'b1;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_r        <= 8'h00;
`endif
    end else begin
      mem_we   <= 1'b0;
      // Release the CPU one cycle after DONE is entered; a new SYNC overrides below.
      cpu_hold <= (state_r != DONE);
      if (in_valid) begin
        case (state_r)
          IDLE, DONE, ERR: begin
            if (is_sync_s) begin
              state_r    <= ADDR_HI;
              load_done  <= 1'b0;
              load_err   <= 1'b0;
              cpu_hold   <= 1'b1;
              byte_cnt_r <= 2'd0;
`ifdef PROG_LOADER_CHKSUM_EN
              chk_r      <= 8'h00;
`endif
            end else begin
              state_r <= state_r;
            end
          end
          ADDR_HI: begin
            addr_hi_r <= in_data;
            state_r   <= ADDR_LO;
          end
          ADDR_LO: begin
            start_r <= ADDR_W'({addr_hi_r, in_data});
            state_r <= CNT_HI;
          end
          CNT_HI: begin
            cnt_hi_r <= in_data;
            state_r  <= CNT_LO;
          end
          CNT_LO: begin
            if ((n_s == 16'h0000) || (end_s > MEM_WORDS)) begin
              state_r  <= ERR;
              load_err <= 1'b1;
            end else begin
              state_r      <= DATA;
              words_left_r <= n_s;
              wr_addr_r    <= start_r;
              byte_cnt_r   <= 2'd0;
            end
          end
          DATA: begin
`ifdef PROG_LOADER_CHKSUM_EN
            chk_r <= chk_update(chk_r, in_data);
`endif
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              mem_we       <= 1'b1;
              mem_addr     <= wr_addr_r;
              mem_wdata    <= WORD_SIZE'(word_s);
              wr_addr_r    <= wr_addr_r + ADDR_W'(1);
              words_left_r <= words_left_r - 16'd1;
              if (words_left_r == 16'd1) begin
`ifdef PROG_LOADER_CHKSUM_EN
                state_r <= CHK;
`else
                state_r   <= DONE;
                load_done <= 1'b1;
`endif
              end else begin
                state_r <= DATA;
              end
            end else begin
              word_sh_r <= {word_sh_r[15:0], in_data};
            end
          end
`ifdef PROG_LOADER_CHKSUM_EN
          CHK: begin
            if (in_data == chk_r) begin
              state_r   <= DONE;
              load_done <= 1'b1;
            end else begin
              state_r  <= ERR;
              load_err <= 1'b1;
            end
          end
`endif
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
